// File: rtl/proj_pkg.sv
// Shared constants and types for the FM buffer and the minimizer/MinHash datapath.
package proj_pkg;

    localparam int FM_ADDRESS_READ_COUNT = 8;
    localparam int FM_GENOME_BTYE        = 8;

    localparam int          MH_WINDOW    = 16;
    localparam int          MH_HASH_BITS = 32;
    localparam logic [31:0] MH_HASH_SEED = 32'h9E3779B1;

    typedef enum logic [1:0] {
        NT_A,
        NT_C,
        NT_G,
        NT_T
    } nt_code_t;

    typedef enum logic [0:0] {
        MH_IDLE,
        MH_ACCUM
    } mh_state_t;

endpackage

// File: rtl/proj_kmer_hash.sv
// Encodes a k-mer window to 2-bit nucleotides and registers the seeded product (stage 1).
module proj_kmer_hash
    import proj_pkg::*;
#(
    parameter int                    KMER_BYTES = FM_ADDRESS_READ_COUNT,
    parameter int                    DATA_BITS  = FM_GENOME_BTYE,
    parameter int                    HASH_BITS  = MH_HASH_BITS,
    parameter logic [HASH_BITS-1:0]  HASH_SEED  = HASH_BITS'(MH_HASH_SEED)
) (
    input  logic                             clk,
    input  logic [KMER_BYTES*DATA_BITS-1:0]  kmer,
    output logic [HASH_BITS-1:0]             mult_p1,
    output logic                             bad_p1
);

    // Returns {invalid, code}; any byte outside ACGT/acgt flags the k-mer invalid.
    function automatic logic [2:0] nt_encode(input logic [DATA_BITS-1:0] b);
        logic [2:0] r;
        case (b)
            DATA_BITS'(8'h41), DATA_BITS'(8'h61): r = {1'b0, NT_A};
            DATA_BITS'(8'h43), DATA_BITS'(8'h63): r = {1'b0, NT_C};
            DATA_BITS'(8'h47), DATA_BITS'(8'h67): r = {1'b0, NT_G};
            DATA_BITS'(8'h54), DATA_BITS'(8'h74): r = {1'b0, NT_T};
            default:                              r = {1'b1, NT_A};
        endcase
        return r;
    endfunction

    logic [2:0]              enc [KMER_BYTES];
    logic [2*KMER_BYTES-1:0] packed_nt;
    logic                    bad;
    logic [HASH_BITS-1:0]    mult;

    for (genvar i = 0; i < KMER_BYTES; i++) begin : g_enc
        assign enc[i] = nt_encode(kmer[i*DATA_BITS +: DATA_BITS]);
    end

    always_comb begin
        packed_nt = '0;
        bad       = 1'b0;
        for (int i = 0; i < KMER_BYTES; i++) begin
            packed_nt[2*i +: 2] = enc[i][1:0];
            bad                 = bad | enc[i][2];
        end
    end

    assign mult = HASH_BITS'(packed_nt) * HASH_SEED;

    // stage 1: product and invalid flag
    always_ff @(posedge clk) begin
        mult_p1 <= mult;
        bad_p1  <= bad;
    end

endmodule

// File: rtl/proj_minimizer_sel.sv
// Minimizer selector: minimum k-mer hash per group of WINDOW beats, one-entry record output.
module proj_minimizer_sel
    import proj_pkg::*;
#(
    parameter int                    KMER_BYTES = FM_ADDRESS_READ_COUNT,
    parameter int                    DATA_BITS  = FM_GENOME_BTYE,
    parameter int                    WINDOW     = MH_WINDOW,
    parameter int                    HASH_BITS  = MH_HASH_BITS,
    parameter logic [HASH_BITS-1:0]  HASH_SEED  = HASH_BITS'(MH_HASH_SEED),
    parameter int                    POS_BITS   = 16
) (
    input  logic                             in_clk,
    input  logic                             in_rst,
    input  logic                             in_valid,
    input  logic [KMER_BYTES*DATA_BITS-1:0]  in_kmer,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [HASH_BITS-1:0]             out_hash,
    output logic [POS_BITS-1:0]              out_pos,
    output logic                             out_overflow
);

    localparam int CNT_W = $clog2(WINDOW);

    function automatic logic [HASH_BITS-1:0] xor_shift(input logic [HASH_BITS-1:0] m);
        return m ^ (m >> 15);
    endfunction

    logic [CNT_W-1:0]     cnt;
    logic [POS_BITS-1:0]  pos;
    logic                 close_in;

    logic                 vld_p1;
    logic                 close_p1;
    logic [POS_BITS-1:0]  pos_p1;
    logic [HASH_BITS-1:0] mult_p1;
    logic                 bad_p1;

    mh_state_t            state, state_next;
    logic                 have_min;
    logic [HASH_BITS-1:0] min_hash;
    logic [POS_BITS-1:0]  min_pos;

    logic [HASH_BITS-1:0] hash_p2;
    logic                 cand;
    logic                 has_after;
    logic                 emit;
    logic [HASH_BITS-1:0] sel_hash;
    logic [POS_BITS-1:0]  sel_pos;

    assign close_in = in_last || (cnt == CNT_W'(WINDOW - 1));

    proj_kmer_hash #(
        .KMER_BYTES (KMER_BYTES),
        .DATA_BITS  (DATA_BITS),
        .HASH_BITS  (HASH_BITS),
        .HASH_SEED  (HASH_SEED)
    ) u_kmer_hash (
        .clk     (in_clk),
        .kmer    (in_kmer),
        .mult_p1 (mult_p1),
        .bad_p1  (bad_p1)
    );

    // stage 1: beat position, group-close flag and beat valid
    always_ff @(posedge in_clk) begin
        pos_p1   <= pos;
        close_p1 <= close_in;
        if (in_rst) begin
            cnt    <= '0;
            pos    <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                cnt <= close_in ? '0 : cnt + CNT_W'(1);
                pos <= in_last  ? '0 : pos + POS_BITS'(1);
            end
        end
    end

    // stage 2: finish the hash, compare against the running minimum, run the group FSM
    assign hash_p2   = xor_shift(mult_p1);
    assign cand      = vld_p1 && !bad_p1 && (!have_min || (hash_p2 < min_hash));
    assign has_after = have_min || (vld_p1 && !bad_p1);
    assign sel_hash  = cand ? hash_p2 : min_hash;
    assign sel_pos   = cand ? pos_p1  : min_pos;

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        case (state)
            MH_IDLE: begin
                // A group that closes on its very first beat never leaves IDLE and emits nothing.
                if (vld_p1 && !close_p1) state_next = MH_ACCUM;
            end
            MH_ACCUM: begin
                if (vld_p1 && close_p1) begin
                    emit       = has_after;
                    state_next = MH_IDLE;
                end
            end
            default: state_next = MH_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (cand) begin
            min_hash <= hash_p2;
            min_pos  <= pos_p1;
        end
        if (in_rst) begin
            state    <= MH_IDLE;
            have_min <= 1'b0;
        end else begin
            state <= state_next;
            if (vld_p1) have_min <= close_p1 ? 1'b0 : has_after;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_valid    <= 1'b0;
            out_hash     <= '0;
            out_pos      <= '0;
            out_overflow <= 1'b0;
        end else begin
            if (emit && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_hash  <= sel_hash;
                out_pos   <= sel_pos;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A record arriving while the held one is stuck is dropped.
            if (emit && out_valid && !out_ready) out_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_proj_minimizer_sel.sv
// Directed bench for proj_minimizer_sel: table of group vectors plus backpressure and reset sequences.
module tb_proj_minimizer_sel;

    localparam logic [63:0] A8 = "AAAAAAAA";
    localparam logic [63:0] C8 = "CCCCCCCC";

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_kmer = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_hash;
    logic [15:0] out_pos;
    logic        out_overflow;

    always #5 in_clk = ~in_clk;

    proj_minimizer_sel dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_valid     (in_valid),
        .in_kmer      (in_kmer),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_hash     (out_hash),
        .out_pos      (out_pos),
        .out_overflow (out_overflow)
    );

    int cyc = 0;
    always @(posedge in_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] h;
        logic [15:0] p;
        int          c;
    } rec_t;
    rec_t recq[$];

    always @(negedge in_clk) begin
        if (out_valid && out_ready) recq.push_back('{out_hash, out_pos, cyc});
    end

    typedef struct {
        int          n;
        int          last_at;
        int          sa;
        int          sb;
        logic [63:0] base;
        logic [63:0] spec;
        int          exp_idx;
        int          exp_rec;
    } row_t;

    int n_vec  = 0;
    int n_miss = 0;
    int tb_pos = 0;

    function automatic logic [31:0] hash_of(input logic [63:0] k);
        logic [15:0] p;
        logic [31:0] m;
        logic [7:0]  b;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            b = k[8*i +: 8];
            case (b)
                8'h43, 8'h63: p[2*i +: 2] = 2'd1;
                8'h47, 8'h67: p[2*i +: 2] = 2'd2;
                8'h54, 8'h74: p[2*i +: 2] = 2'd3;
                default:      p[2*i +: 2] = 2'd0;
            endcase
        end
        m = {16'h0, p} * 32'h9E3779B1;
        return m ^ (m >> 15);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] k, input logic l, output int bp, output int bc);
        step();
        in_valid = 1'b1;
        in_kmer  = k;
        in_last  = l;
        bp       = tb_pos;
        bc       = cyc;
        tb_pos   = l ? 0 : tb_pos + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic run_row(input row_t r, input string nm);
        logic [63:0] k;
        logic [63:0] exp_k;
        int          bp, bc, exp_pos, close_c;
        recq.delete();
        exp_k   = '0;
        exp_pos = 0;
        close_c = 0;
        for (int i = 0; i < r.n; i++) begin
            k = (i == r.sa || i == r.sb) ? r.spec : r.base;
            beat(k, (i == r.last_at), bp, bc);
            if (i == r.exp_idx) begin
                exp_pos = bp;
                exp_k   = k;
            end
            close_c = bc;
        end
        idle(4);
        chk({nm, "_records"}, 64'(recq.size()), 64'(r.exp_rec));
        if (r.exp_rec == 1 && recq.size() == 1) begin
            chk({nm, "_hash"}, 64'(recq[0].h), 64'(hash_of(exp_k)));
            chk({nm, "_pos"}, 64'(recq[0].p), 64'(exp_pos[15:0]));
            chk({nm, "_latency"}, 64'(recq[0].c), 64'(close_c + 2));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t rows[11];
        int   p1, p2, p3, bp, bc, c1;

        rows[0]  = '{16, -1,  5, -1, C8,         A8,         5, 1};
        rows[1]  = '{16, -1,  3,  9, C8,         A8,         3, 1};
        rows[2]  = '{16, -1, -1, -1, "ACGTNACG", C8,        -1, 0};
        rows[3]  = '{16, -1,  2, -1, C8,         "AAAANAAA", 0, 1};
        rows[4]  = '{ 5,  4,  2, -1, C8,         A8,         2, 1};
        rows[5]  = '{16, -1,  7, -1, C8,         A8,         7, 1};
        rows[6]  = '{ 1,  0, -1, -1, A8,         A8,        -1, 0};
        rows[7]  = '{16, -1, 11, -1, "cccccccc", "aaaaaaaa", 11, 1};
        rows[8]  = '{16, -1, -1, -1, "gGgGgGgG", C8,         0, 1};
        rows[9]  = '{16, -1, 15, -1, "TtTtTtTt", "NNNNNNNN", 0, 1};
        rows[10] = '{16, -1,  0, -1, "ACGTNACG", "AcGtAcGt", 0, 1};

        idle(3);
        @(negedge in_clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_hash", 64'(out_hash), 64'd0);
        chk("rst_pos", 64'(out_pos), 64'd0);
        chk("rst_overflow", 64'(out_overflow), 64'd0);
        step();
        in_rst = 1'b0;
        tb_pos = 0;

        for (int i = 0; i < 11; i++) run_row(rows[i], $sformatf("row%0d", i));
        chk("ovf_after_rows", 64'(out_overflow), 64'd0);

        // Held record transfers on the same edge the next one loads.
        out_ready = 1'b0;
        beat(C8, 1'b0, bp, bc);
        beat(A8, 1'b1, p1, c1);
        beat(A8, 1'b0, p2, bc);
        beat(C8, 1'b1, bp, bc);
        @(negedge in_clk);
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_pos", 64'(out_pos), 64'(p1[15:0]));
        chk("hold_lat", 64'(cyc), 64'(c1 + 2));
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge in_clk);
        chk("swap_valid", 64'(out_valid), 64'd1);
        chk("swap_pos", 64'(out_pos), 64'(p2[15:0]));
        chk("swap_overflow", 64'(out_overflow), 64'd0);

        // Second record while the register is stuck: dropped, sticky overflow.
        beat(C8, 1'b0, bp, bc);
        beat(A8, 1'b1, p3, bc);
        idle(3);
        @(negedge in_clk);
        chk("drop_valid", 64'(out_valid), 64'd1);
        chk("drop_pos", 64'(out_pos), 64'(p2[15:0]));
        chk("drop_hash", 64'(out_hash), 64'd0);
        chk("drop_overflow", 64'(out_overflow), 64'd1);

        // Reset in the middle of a group.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) beat((i == 2) ? A8 : C8, 1'b0, bp, bc);
        step();
        in_valid = 1'b0;
        in_rst   = 1'b1;
        @(negedge in_clk);
        chk("pre_rst_overflow", 64'(out_overflow), 64'd1);
        step();
        in_rst = 1'b0;
        tb_pos = 0;
        @(negedge in_clk);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_hash", 64'(out_hash), 64'd0);
        chk("midrst_pos", 64'(out_pos), 64'd0);
        chk("midrst_overflow", 64'(out_overflow), 64'd0);
        run_row('{16, -1, 12, -1, C8, A8, 12, 1}, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
